// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - E-stage bundle between the pipeline and the HI/LO multiply/divide unit
//
// Pipeline side (master) drives: clr, HILOOp, A, B
// MDU side (slave) drives:       HILO, Busy, Start
interface hilo_mdu_if;
    logic        clr;
    logic [3:0]  HILOOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HILO;
    logic        Busy;
    logic        Start;

    modport master (
        output clr, HILOOp, A, B,
        input  HILO, Busy, Start
    );

    modport slave (
        input  clr, HILOOp, A, B,
        output HILO, Busy, Start
    );
endinterface

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - multiply/divide unit with HI/LO registers for the E stage
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears HI/LO and any in-flight op
//   bus.clr      squashes this cycle's HILOOp (bubble in E)
//   bus.HILOOp   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   bus.A/B      forwarded rs/rt operands
//   bus.HILO     mfhi/mflo read value, 0 for any other op
//   bus.Busy     high while a mult/div result is pending
//   bus.Start    a mult/div is being accepted at this edge
module hilo_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    hilo_mdu_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    logic [31:0] hi, lo;
    logic [31:0] ph, pl;
    logic [3:0]  cnt;
    logic        pend_wr;

    logic        busy;
    logic        start;
    logic        is_muldiv;

    assign busy      = (cnt != 4'd0);
    assign is_muldiv = (bus.HILOOp >= OP_MULT) && (bus.HILOOp <= OP_DIVU);
    assign start     = is_muldiv && !busy && !bus.clr;

    assign bus.Busy  = busy;
    assign bus.Start = start;
    assign bus.HILO  = (bus.HILOOp == OP_MFHI) ? hi :
                       (bus.HILOOp == OP_MFLO) ? lo : 32'd0;

    // Both products computed at full 64-bit width on explicitly extended
    // operands so the low 64 bits are the exact signed/unsigned result.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide is done on magnitudes and the signs restored afterwards.
    // This naturally yields 0x80000000 / -1 = 0x80000000 rem 0 without a
    // special case, since |0x80000000| fits in 32 unsigned bits.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_den;
    logic [31:0] q_mag, r_mag, quot, rem;

    assign a_neg   = (bus.HILOOp == OP_DIV) && bus.A[31];
    assign b_neg   = (bus.HILOOp == OP_DIV) && bus.B[31];
    assign a_mag   = a_neg ? (~bus.A + 32'd1) : bus.A;
    assign b_mag   = b_neg ? (~bus.B + 32'd1) : bus.B;
    // Divide-by-zero never commits; a dummy divisor keeps the datapath defined.
    assign div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / div_den;
    assign r_mag   = a_mag % div_den;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            ph      <= 32'd0;
            pl      <= 32'd0;
            cnt     <= 4'd0;
            pend_wr <= 1'b0;
        end else if (start) begin
            case (bus.HILOOp)
                OP_MULT: begin
                    {ph, pl} <= prod_s;
                    cnt      <= MULT_LAT;
                    pend_wr  <= 1'b1;
                end
                OP_MULTU: begin
                    {ph, pl} <= prod_u;
                    cnt      <= MULT_LAT;
                    pend_wr  <= 1'b1;
                end
                default: begin
                    ph      <= rem;
                    pl      <= quot;
                    cnt     <= DIV_LAT;
                    pend_wr <= (bus.B != 32'd0);
                end
            endcase
        end else if (busy) begin
            // Ops presented while busy are ignored; clr does not abort.
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                pend_wr <= 1'b0;
                if (pend_wr) begin
                    hi <= ph;
                    lo <= pl;
                end
            end
        end else if (!bus.clr) begin
            if (bus.HILOOp == OP_MTHI) hi <= bus.A;
            if (bus.HILOOp == OP_MTLO) lo <= bus.A;
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - scoreboard testbench for hilo_mdu
module tb_hilo_mdu;
    logic clk;
    logic reset;
    hilo_mdu_if bus();

    hilo_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t hl_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   failures = 0;
    int   run = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: busy-run lengths against expected latencies, HILO reads against expected values.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else if (bus.Busy === 1'b1) begin
            run++;
        end else if (run > 0) begin
            if (lat_q.size() == 0) begin
                check("unexpected_busy_run", run, 0);
            end else begin
                check("busy_cycles", run, lat_q.pop_front());
            end
            run = 0;
        end
        if (!reset && (bus.HILOOp == 4'd5 || bus.HILOOp == 4'd6) && hl_q.size() > 0) begin
            exp_t e;
            e = hl_q.pop_front();
            check(e.name, bus.HILO, e.val);
        end
    end

    task automatic read_hl(input logic [3:0] op, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        bus.HILOOp = op;
        hl_q.push_back('{name, exp});
        @(negedge clk); #1;
        bus.HILOOp = 4'd0;
    endtask

    // Presents a mult/div, checks Start, and leaves after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit now, input string name);
        if (!now) begin
            @(posedge clk); #1;
        end
        bus.HILOOp = op;
        bus.A = a;
        bus.B = b;
        #1;
        check({"start_", name}, bus.Start, 1'b1);
        if (lat > 0) lat_q.push_back(lat);
        @(posedge clk); #1;
        bus.HILOOp = 4'd0;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        @(posedge clk); #1;
        bus.HILOOp = op;
        bus.A = a;
        @(posedge clk); #1;
        bus.HILOOp = 4'd0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.Busy === 1'b1 && k < 40);
        check({"idle_", name}, bus.Busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.clr = 1'b0;
        bus.HILOOp = 4'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.Busy, 1'b0);
        check("reset_start", bus.Start, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        read_hl(4'd5, 32'h0, "reset_hi");
        read_hl(4'd6, 32'h0, "reset_lo");

        issue(4'd1, 32'hFFFFFFFF, 32'd2, 5, 1'b0, "mult");
        wait_idle("mult");
        read_hl(4'd5, 32'hFFFFFFFF, "mult_hi");
        read_hl(4'd6, 32'hFFFFFFFE, "mult_lo");

        issue(4'd2, 32'hFFFFFFFF, 32'd2, 5, 1'b0, "multu");
        wait_idle("multu");
        issue(4'd4, 32'd7, 32'd2, 10, 1'b1, "divu_b2b");
        read_hl(4'd5, 32'h00000001, "multu_hi_during_busy");
        read_hl(4'd6, 32'hFFFFFFFE, "multu_lo_during_busy");
        wait_idle("divu");
        read_hl(4'd6, 32'd3, "divu_lo");
        read_hl(4'd5, 32'd1, "divu_hi");

        issue(4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, "div_neg");
        wait_idle("div_neg");
        read_hl(4'd6, 32'hFFFFFFFD, "div_neg_lo");
        read_hl(4'd5, 32'hFFFFFFFF, "div_neg_hi");

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, "div_ovf");
        wait_idle("div_ovf");
        read_hl(4'd6, 32'h80000000, "div_ovf_lo");
        read_hl(4'd5, 32'h00000000, "div_ovf_hi");

        mt(4'd7, 32'h1234);
        read_hl(4'd5, 32'h1234, "mthi");
        issue(4'd3, 32'd5, 32'd0, 10, 1'b0, "div0");
        wait_idle("div0");
        read_hl(4'd5, 32'h1234, "div0_hi");
        read_hl(4'd6, 32'h80000000, "div0_lo");

        issue(4'd1, 32'd3, 32'hFFFFFFFE, 5, 1'b0, "mult_clr");
        bus.clr = 1'b1;
        bus.HILOOp = 4'd7;
        bus.A = 32'hDEAD;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        bus.HILOOp = 4'd0;
        wait_idle("mult_clr");
        read_hl(4'd5, 32'hFFFFFFFF, "mult_clr_hi");
        read_hl(4'd6, 32'hFFFFFFFA, "mult_clr_lo");

        @(posedge clk); #1;
        bus.clr = 1'b1;
        bus.HILOOp = 4'd7;
        bus.A = 32'h5555;
        @(posedge clk); #1;
        bus.HILOOp = 4'd1;
        bus.A = 32'd2;
        bus.B = 32'd3;
        #1;
        check("clr_start", bus.Start, 1'b0);
        @(posedge clk); #1;
        check("clr_busy", bus.Busy, 1'b0);
        bus.clr = 1'b0;
        bus.HILOOp = 4'd0;
        read_hl(4'd5, 32'hFFFFFFFF, "clr_mthi_hi");
        mt(4'd8, 32'hABCD);
        read_hl(4'd6, 32'hABCD, "mtlo");

        issue(4'd3, 32'd100, 32'd7, 0, 1'b0, "div_rst");
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_busy_async", bus.Busy, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_busy", bus.Busy, 1'b0);
        read_hl(4'd5, 32'h0, "post_reset_hi");
        read_hl(4'd6, 32'h0, "post_reset_lo");

        repeat (2) @(negedge clk);
        check("lat_q_empty", lat_q.size(), 0);
        check("hl_q_empty", hl_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multiply/divide unit with HI/LO registers for the five-stage pipeline. Sits in the E stage and consumes the HILO operation code, operands and clear carried by the E-stage pipeline register. It returns `Busy` to the hazard unit so the pipeline registers stall while a multi-cycle operation is in flight, and it supplies the mfhi/mflo read value to the E→M datapath.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: Busy duration for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: Busy duration for div/divu; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `clr` input 1: synchronous squash of this cycle's operation; a bubble is in E.
- `HILOOp` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 are treated as none.
- `A` input 32: forwarded rs value.
- `B` input 32: forwarded rt value.
- `HILO` output 32: HI when `HILOOp`=5, LO when `HILOOp`=6, otherwise 0; combinational from the registers.
- `Busy` output 1: high while a mult/div operation is pending.
- `Start` output 1: combinational; `(HILOOp` in 1..4`) & !Busy & !clr`.

## Operation
- State: HI[31:0], LO[31:0], pending result PH/PL[31:0], down-counter CNT[3:0], pending-write flag.
- Accept: on an edge where `Start`=1, compute the result from `A`/`B` at that edge into PH/PL and load CNT with the latency for that op.
  - mult: signed 64-bit product. multu: unsigned 64-bit product. For both, {PH,PL} = product.
  - div: signed, quotient truncates toward zero. PL = quotient, PH = remainder, with the remainder taking the dividend's sign.
  - divu: unsigned; PL = quotient, PH = remainder.
  - div 0x80000000 / 0xFFFFFFFF: PL = 0x80000000, PH = 0.
  - Divide by zero (B = 0, div or divu): the op is accepted and Busy runs the full DIV_CYCLES, but HI/LO are left unchanged.
- Busy: `Busy` = (CNT != 0). CNT decrements by 1 every edge while it is nonzero.
- Commit: on the edge where CNT goes 1→0, HI←PH and LO←PL, unless the op was a divide by zero.
- mthi/mtlo: on an edge with `HILOOp`=7 (or 8), `!Busy` and `!clr`, HI←A (or LO←A).
- While `Busy`=1, every `HILOOp` value is ignored; holding it stable is the hazard unit's job. mfhi/mflo still drive `HILO` from the old HI/LO.
- `clr`=1: that cycle's `HILOOp` is ignored. `clr` does not abort an in-flight op; CNT keeps counting and the result still commits.
- Reset, asynchronous: HI = LO = PH = PL = 0, CNT = 0, and the pending flag is cleared. An in-flight op is discarded with no commit.

## Timing
- Reset values: `Busy`=0, `Start`=0 unless a start op is presented, `HILO`=0 or the zeroed HI/LO.
- Accept at edge E0:
  - `Busy` is high in the cycles after E0 through edge E0+LAT, i.e. exactly LAT cycles.
  - HI/LO take the new value at edge E0+LAT, the same edge where `Busy` falls.
  - An mfhi/mflo presented in the cycle after `Busy` falls reads the new value.
- Back-to-back: a new start op presented in the cycle right after `Busy` falls is accepted at that cycle's edge. There is no dead cycle.
- A start op presented while `Busy`=1 is not accepted. It is accepted on the first edge with `Busy`=0, if it is still presented.
- mthi/mtlo: single-cycle. Visible on `HILO` in the next cycle.
- Release of reset mid-cycle: the first edge after reset deasserts may accept an op.

## Test plan
- Reset, then mult with A=0xFFFFFFFF (−1), B=2 → Busy high for exactly 5 cycles; afterwards mfhi=0xFFFFFFFF, mflo=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. Immediately follow with divu A=7, B=2 in the next cycle → accepted with no gap; after 10 cycles LO=3, HI=1.
- div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x1234, then div A=5, B=0 → Busy high for 10 cycles; HI stays 0x1234 and LO is unchanged.
- mult issued, then `clr`=1 with HILOOp=7 presented during Busy → no write; the mult still commits on time. A start op with `clr`=1 while idle → Start=0 and Busy stays 0.
- div accepted, then `reset` pulsed at cycle 4 → Busy=0 immediately; HI=LO=0 and no later commit occurs.
